ssd_share_ctrl: RTL

//  Scan controller and arbiter for the 4-digit seven-segment display.
//  Two requesters (A, B) each offer a 16-bit, 4-nibble value.
//  - Grants the display to one requester at a time, using req/gnt and a minimum hold.
//  - Multiplexes the owner's nibbles onto o_Out/o_Anodes with a blanking gap per digit.
//  - o_Out feeds the segment decoder; o_Anodes drives the board anodes, active-low.

---
 rtl/ssd_share_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ssd_share_ctrl.sv
// ssd_share_ctrl
//   Scan controller and two-way arbiter for a 4-digit seven-segment display.
//   Requesters A and B each offer a 16-bit value (four nibbles, [15:12] is the
//   leftmost digit). One owner at a time is granted the display. The owner's
//   value is latched once per frame and scanned one digit per slot, with a
//   blanking gap at the start of every slot.
//
//   States:
//     IDLE  | nobody owns the display; anodes off, o_Out = 0
//     OWN_A | requester A owns the display
//     OWN_B | requester B owns the display
//
// Ports
//   i_CLK      in   system clock
//   i_RST      in   synchronous reset, active-high
//   i_Req_A    in   requester A wants the display (level)
//   i_Data_A   in   [15:0] A value, [15:12] = leftmost digit
//   i_Req_B    in   requester B wants the display (level)
//   i_Data_B   in   [15:0] B value, same nibble order
//   o_Gnt_A    out  A owns the display
//   o_Gnt_B    out  B owns the display (never together with o_Gnt_A)
//   o_Out      out  [3:0] nibble for the current slot (to the segment decoder)
//   o_Anodes   out  [3:0] active-low anode enables
//   o_Frame    out  one-clock pulse on the last clock of each frame
module ssd_share_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_Req_A,
  input  logic [15:0] i_Data_A,
  input  logic        i_Req_B,
  input  logic [15:0] i_Data_B,
  output logic        o_Gnt_A,
  output logic        o_Gnt_B,
  output logic [3:0]  o_Out,
  output logic [3:0]  o_Anodes,
  output logic        o_Frame
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [PW-1:0] PRE_TOP  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  logic [PW-1:0] prescaler;
  logic [1:0]    slot;
  state_t        state, state_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [HW-1:0] owned_cnt;
  logic          last_b, last_b_nxt;   // 1: B was the most recent owner
  logic [15:0]   snapshot, snapshot_nxt;
  logic          frame_end;
  logic          blank_win;

  assign frame_end = (prescaler == PRE_TOP) && (slot == 2'd3);
  assign blank_win = (int'(prescaler) < BLANK_CYC);

  // Frames owned including the one that is ending now, saturating. Comparing
  // this (rather than the stored count) lets an owner keep the display for
  // exactly HOLD_FRAMES frames before yielding to a waiting requester.
  assign owned_cnt = (hold == HOLD_MAX) ? HOLD_MAX : hold + 1'b1;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      prescaler <= '0;
      slot      <= 2'd0;
      state     <= IDLE;
      hold      <= '0;
      last_b    <= 1'b1;
      snapshot  <= 16'd0;
    end else begin
      if (prescaler == PRE_TOP) begin
        prescaler <= '0;
        slot      <= slot + 2'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      state    <= state_nxt;
      hold     <= hold_nxt;
      last_b   <= last_b_nxt;
      snapshot <= snapshot_nxt;
    end
  end

  // Arbitration and snapshot capture happen only on the frame-boundary edge,
  // so a grant change and its data always start together at slot 0.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold;
    last_b_nxt   = last_b;
    snapshot_nxt = snapshot;
    if (frame_end) begin
      case (state)
        IDLE: begin
          hold_nxt = '0;
          if (i_Req_A && (!i_Req_B || last_b)) begin
            state_nxt = OWN_A;
          end else if (i_Req_B) begin
            state_nxt = OWN_B;
          end
        end
        OWN_A: begin
          if (!i_Req_A) begin
            state_nxt  = i_Req_B ? OWN_B : IDLE;
            hold_nxt   = '0;
            last_b_nxt = 1'b0;
          end else if (i_Req_B && (owned_cnt == HOLD_MAX)) begin
            state_nxt  = OWN_B;
            hold_nxt   = '0;
            last_b_nxt = 1'b0;
          end else begin
            hold_nxt = owned_cnt;
          end
        end
        OWN_B: begin
          if (!i_Req_B) begin
            state_nxt  = i_Req_A ? OWN_A : IDLE;
            hold_nxt   = '0;
            last_b_nxt = 1'b1;
          end else if (i_Req_A && (owned_cnt == HOLD_MAX)) begin
            state_nxt  = OWN_A;
            hold_nxt   = '0;
            last_b_nxt = 1'b1;
          end else begin
            hold_nxt = owned_cnt;
          end
        end
        default: begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end
      endcase

      case (state_nxt)
        OWN_A:   snapshot_nxt = i_Data_A;
        OWN_B:   snapshot_nxt = i_Data_B;
        default: snapshot_nxt = 16'd0;
      endcase
    end
  end

  always_comb begin
    o_Out    = 4'd0;
    o_Anodes = 4'b1111;
    if (state != IDLE) begin
      case (slot)
        2'd0:    o_Out = snapshot[15:12];
        2'd1:    o_Out = snapshot[11:8];
        2'd2:    o_Out = snapshot[7:4];
        default: o_Out = snapshot[3:0];
      endcase
      if (!blank_win) begin
        case (slot)
          2'd0:    o_Anodes = 4'b0111;
          2'd1:    o_Anodes = 4'b1011;
          2'd2:    o_Anodes = 4'b1101;
          default: o_Anodes = 4'b1110;
        endcase
      end
    end
  end

  assign o_Gnt_A = (state == OWN_A);
  assign o_Gnt_B = (state == OWN_B);
  assign o_Frame = frame_end;

endmodule
